// File: rtl/fork_ctrl_pkg.sv
// Shared types and default parameters for the eager 1-to-N fork controller.
package fork_ctrl_pkg;

  typedef enum logic {
    FORK_IDLE    = 1'b0,
    FORK_PARTIAL = 1'b1
  } fork_state_t;

  localparam int WD_W_DEF     = 16;
  localparam int WD_LIMIT_DEF = 1000;

endpackage

// File: rtl/fork_ctrl_if.sv
// Fork controller bus: one upstream stream, N downstream branch streams.
interface fork_ctrl_if #(
  parameter int N = 10
);

  // Valid/ready: a transfer happens on a rising clk edge where both valid and
  // ready are high; valid and its payload must hold until that edge, and
  // ready may depend combinationally on valid.
  logic [N-1:0] branch_mask_in;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [N-1:0] data_out_valid;
  logic [N-1:0] data_out_ready;
  logic [N-1:0] pending_out;
  logic         stall_out;

  modport master (
    output branch_mask_in,
    output data_in_valid,
    output data_out_ready,
    input  data_in_ready,
    input  data_out_valid,
    input  pending_out,
    input  stall_out
  );

  modport slave (
    input  branch_mask_in,
    input  data_in_valid,
    input  data_out_ready,
    output data_in_ready,
    output data_out_valid,
    output pending_out,
    output stall_out
  );

endinterface

// File: rtl/fork_ctrl_watchdog.sv
// Saturating stall counter: flags an input token that has waited WD_LIMIT
// cycles or more without being consumed.
module fork_ctrl_watchdog #(
  parameter int WD_W     = 16,
  parameter int WD_LIMIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_ready,
  output logic stall
);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  // The count restarts whenever the token leaves or upstream is idle.
  always_comb begin
    cnt_d = cnt_q;
    if (!in_valid || in_ready) begin
      cnt_d = '0;
    end else if (cnt_q != {WD_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      stall <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stall <= (cnt_d >= WD_W'(WD_LIMIT));
    end
  end

endmodule

// File: rtl/fork_ctrl_n.sv
// Eager 1-to-N stream fork: branches take the token independently, the input
// is consumed once every masked branch has it. Optional stall watchdog under
// FORK_CTRL_WATCHDOG_EN.
module fork_ctrl_n
  import fork_ctrl_pkg::*;
#(
  parameter int N        = 10,
  parameter int WD_W     = WD_W_DEF,
  parameter int WD_LIMIT = WD_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  fork_ctrl_if.slave  io,
  output fork_state_t state_dbg
);

  fork_state_t  state_q;
  logic [N-1:0] done_q;
  logic [N-1:0] mask_q;

  logic [N-1:0] mask_eff;
  logic [N-1:0] out_valid;
  logic [N-1:0] acc;
  logic         in_ready;

  if (WD_LIMIT >= (2 ** WD_W)) begin : g_bad_limit
    $error("fork_ctrl_n: WD_LIMIT must be below 2**WD_W");
  end

  // Once any branch has the token, its mask is frozen so late mask changes
  // cannot add or drop branches mid-token.
  assign mask_eff  = (state_q == FORK_IDLE) ? io.branch_mask_in : mask_q;
  assign out_valid = {N{io.data_in_valid & ~rst}} & mask_eff & ~done_q;
  assign acc       = out_valid & io.data_out_ready;
  assign in_ready  = io.data_in_valid & ~rst & (&(done_q | acc | ~mask_eff));

  assign io.data_out_valid = out_valid;
  assign io.data_in_ready  = in_ready;
  assign io.pending_out    = out_valid;
  assign state_dbg         = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FORK_IDLE;
      done_q  <= '0;
      mask_q  <= '0;
    end else if (in_ready) begin
      state_q <= FORK_IDLE;
      done_q  <= '0;
    end else if (|acc) begin
      done_q <= done_q | acc;
      if (state_q == FORK_IDLE) begin
        mask_q  <= io.branch_mask_in;
        state_q <= FORK_PARTIAL;
      end
    end
  end

`ifdef FORK_CTRL_WATCHDOG_EN
  fork_ctrl_watchdog #(
    .WD_W     (WD_W),
    .WD_LIMIT (WD_LIMIT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .in_valid (io.data_in_valid),
    .in_ready (in_ready),
    .stall    (io.stall_out)
  );
`else
  assign io.stall_out = 1'b0;
`endif

  // Dropping valid with a partly served token would lose it for the others.
  a_hold_valid : assert property (@(posedge clk) disable iff (rst)
    (state_q == FORK_PARTIAL) |-> io.data_in_valid);

endmodule

// File: tb/tb_fork_ctrl_n.sv
// Directed bench for fork_ctrl_n (N=4) with a per-branch service model and
// literal spot checks; watchdog scenario runs when FORK_CTRL_WATCHDOG_EN is set.
module tb_fork_ctrl_n;
  import fork_ctrl_pkg::*;

  localparam int N        = 4;
  localparam int WD_LIMIT = 8;

  logic        clk;
  logic        rst;
  fork_state_t state_dbg;
  int          checks;
  int          errors;

  fork_ctrl_if #(.N(N)) bus ();

  fork_ctrl_n #(
    .N        (N),
    .WD_W     (16),
    .WD_LIMIT (WD_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model + compare ----------------
  // served[i]: branch i already holds the current token; in_flight: some
  // branch has taken it, so tok_mask is the frozen participation set.
  bit served [N];
  bit tok_mask [N];
  bit in_flight;
  int stall_cycles;
  bit exp_stall;

  always @(negedge clk) begin
    logic [N-1:0] e_valid;
    bit part [N];
    bit all_done;
    bit took_any;
    if (rst) begin
      chk("rst_out_valid", 32'(bus.data_out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.data_in_ready), 32'd0);
      chk("rst_pending", 32'(bus.pending_out), 32'd0);
      chk("rst_stall", 32'(bus.stall_out), 32'd0);
      for (int i = 0; i < N; i++) begin
        served[i]   = 1'b0;
        tok_mask[i] = 1'b0;
      end
      in_flight    = 1'b0;
      stall_cycles = 0;
      exp_stall    = 1'b0;
    end else begin
      all_done = 1'b1;
      took_any = 1'b0;
      for (int i = 0; i < N; i++) begin
        part[i]    = in_flight ? tok_mask[i] : bus.branch_mask_in[i];
        e_valid[i] = bus.data_in_valid && part[i] && !served[i];
        if (part[i] && !served[i] && !(e_valid[i] && bus.data_out_ready[i]))
          all_done = 1'b0;
      end
      all_done = all_done && bus.data_in_valid;
      chk("out_valid", 32'(bus.data_out_valid), 32'(e_valid));
      chk("in_ready", 32'(bus.data_in_ready), 32'(all_done));
      chk("pending", 32'(bus.pending_out), 32'(e_valid));
`ifdef FORK_CTRL_WATCHDOG_EN
      chk("stall", 32'(bus.stall_out), 32'(exp_stall));
`else
      chk("stall", 32'(bus.stall_out), 32'd0);
`endif
      if (all_done) begin
        for (int i = 0; i < N; i++) served[i] = 1'b0;
        in_flight = 1'b0;
      end else begin
        for (int i = 0; i < N; i++)
          if (e_valid[i] && bus.data_out_ready[i]) took_any = 1'b1;
        if (took_any && !in_flight) begin
          for (int i = 0; i < N; i++) tok_mask[i] = bus.branch_mask_in[i];
          in_flight = 1'b1;
        end
        for (int i = 0; i < N; i++)
          if (e_valid[i] && bus.data_out_ready[i]) served[i] = 1'b1;
      end
      if (bus.data_in_valid && !all_done) begin
        if (stall_cycles < 65535) stall_cycles++;
      end else begin
        stall_cycles = 0;
      end
      exp_stall = (stall_cycles >= WD_LIMIT);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input bit v, input logic [N-1:0] m, input logic [N-1:0] r);
    @(posedge clk);
    #1;
    bus.data_in_valid  = v;
    bus.branch_mask_in = m;
    bus.data_out_ready = r;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.data_in_valid  = 1'b0;
    bus.branch_mask_in = '0;
    bus.data_out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state_dbg), 32'(FORK_IDLE));
    rst = 1'b0;

    // full broadcast, everyone ready: consumed in cycle 0
    cyc(1'b1, 4'b1111, 4'b1111);
    chk("t1_valid", 32'(bus.data_out_valid), 32'h0f);
    chk("t1_ready", 32'(bus.data_in_ready), 32'd1);
    cyc(1'b0, 4'b0000, 4'b0000);
    chk("t1_after", 32'(bus.data_out_valid), 32'h0);

    // split service: 0011 then 1100
    cyc(1'b1, 4'b1111, 4'b0011);
    chk("t2_c0_valid", 32'(bus.data_out_valid), 32'h0f);
    chk("t2_c0_ready", 32'(bus.data_in_ready), 32'd0);
    cyc(1'b1, 4'b1111, 4'b0000);
    chk("t2_c1_valid", 32'(bus.data_out_valid), 32'h0c);
    chk("t2_c1_pending", 32'(bus.pending_out), 32'h0c);
    chk("t2_c1_state", 32'(state_dbg), 32'(FORK_PARTIAL));
    cyc(1'b1, 4'b1111, 4'b1100);
    chk("t2_c2_valid", 32'(bus.data_out_valid), 32'h0c);
    chk("t2_c2_ready", 32'(bus.data_in_ready), 32'd1);
    cyc(1'b0, 4'b0000, 4'b0000);

    // sparse mask, then empty mask (dropped token)
    cyc(1'b1, 4'b0101, 4'b1111);
    chk("t3_valid", 32'(bus.data_out_valid), 32'h05);
    chk("t3_ready", 32'(bus.data_in_ready), 32'd1);
    cyc(1'b1, 4'b0000, 4'b1111);
    chk("t3_drop_valid", 32'(bus.data_out_valid), 32'h0);
    chk("t3_drop_ready", 32'(bus.data_in_ready), 32'd1);
    cyc(1'b0, 4'b0000, 4'b0000);

    // mask change ignored while partly served
    cyc(1'b1, 4'b0011, 4'b0001);
    chk("t4_c0_valid", 32'(bus.data_out_valid), 32'h03);
    cyc(1'b1, 4'b1111, 4'b1100);
    chk("t4_c1_valid", 32'(bus.data_out_valid), 32'h02);
    chk("t4_c1_ready", 32'(bus.data_in_ready), 32'd0);
    cyc(1'b1, 4'b1111, 4'b1110);
    chk("t4_c2_valid", 32'(bus.data_out_valid), 32'h02);
    chk("t4_c2_ready", 32'(bus.data_in_ready), 32'd1);
    cyc(1'b0, 4'b0000, 4'b0000);

    // reset mid-token, then token re-offered to every masked branch
    cyc(1'b1, 4'b1111, 4'b0001);
    cyc(1'b1, 4'b1111, 4'b0000);
    chk("t5_partial_valid", 32'(bus.data_out_valid), 32'h0e);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus.data_out_valid), 32'h0);
    chk("t5_rst_ready", 32'(bus.data_in_ready), 32'd0);
    chk("t5_rst_state", 32'(state_dbg), 32'(FORK_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_reoffer", 32'(bus.data_out_valid), 32'h0f);
    cyc(1'b1, 4'b1111, 4'b1111);
    chk("t5_done", 32'(bus.data_in_ready), 32'd1);
    cyc(1'b0, 4'b0000, 4'b0000);

`ifdef FORK_CTRL_WATCHDOG_EN
    // branch 3 withheld: stall rises after 8 stalled cycles
    cyc(1'b1, 4'b1111, 4'b0111);
    chk("wd_c0", 32'(bus.stall_out), 32'd0);
    for (int k = 1; k < 10; k++) begin
      cyc(1'b1, 4'b1111, 4'b0000);
      chk("wd_hold", 32'(bus.stall_out), 32'(k >= WD_LIMIT));
    end
    cyc(1'b1, 4'b1111, 4'b1000);
    chk("wd_hs_stall", 32'(bus.stall_out), 32'd1);
    chk("wd_hs_ready", 32'(bus.data_in_ready), 32'd1);
    cyc(1'b0, 4'b0000, 4'b0000);
    chk("wd_clear", 32'(bus.stall_out), 32'd0);
`endif

    cyc(1'b0, 4'b0000, 4'b0000);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fork_ctrl_n.md
# fork_ctrl_n

Eager 1-to-N stream fork controller. Each output branch may accept the current input token on a different cycle; per-branch completion flags track which branches have taken the token, and the input is consumed only once every participating branch has been served. A per-token branch mask selects which branches participate. It replaces the lock-step fork wherever branch consumers drain at independent rates and simultaneous readiness would starve the fork.

## Interface
Parameters:
- N, 10, number of output branches (N >= 1)
- WD_W, 16, watchdog counter width
- WD_LIMIT, 1000, stall cycles before stall_out asserts (must be < 2^WD_W)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- branch_mask_in  input  N  participating branches for the token at data_in; sampled per Operation rules
- data_in_valid  input  1  upstream token valid
- data_in_ready  output  1  token consumed this cycle
- data_out_valid  output  N  per-branch valid
- data_out_ready  input  N  per-branch ready
- pending_out  output  N  participating branches not yet served for the current token
- stall_out  output  1  watchdog flag, input waiting ≥ WD_LIMIT cycles

## Operation
- State: IDLE (no branch has taken the current token) and PARTIAL (at least one has, token not yet consumed). Registers: done_q[N-1:0], mask_q[N-1:0], state.
- Effective mask: mask_eff = branch_mask_in in IDLE, mask_q in PARTIAL.
- data_out_valid[i] = data_in_valid & mask_eff[i] & ~done_q[i].
- acc[i] = data_out_valid[i] & data_out_ready[i].
- data_in_ready = data_in_valid & &(done_q | acc | ~mask_eff).
- pending_out = mask_eff & ~done_q & {N{data_in_valid}}.
- Input handshake (data_in_ready high): next done_q = 0, next state IDLE.
- Otherwise, if any acc: done_q |= acc. In IDLE, also mask_q <= branch_mask_in and state -> PARTIAL.
- All-zero mask_eff with data_in_valid high: token is dropped. data_in_ready = 1 the same cycle, and no branch sees valid.
- N == 1: same logic. The branch serves in one cycle, and PARTIAL is never entered.
- Upstream must hold data_in_valid and data until data_in_ready. If valid drops in PARTIAL, done_q and mask_q hold and all outputs go low. This is a protocol violation and is flagged in simulation by an assertion.

## Timing
- Reset values: state IDLE, done_q 0, mask_q 0, watchdog count 0. Resulting outputs: data_out_valid 0, data_in_ready 0, pending_out 0, stall_out 0.
- Combinational paths:
  - data_in_valid/branch_mask_in → data_out_valid.
  - data_out_ready → data_in_ready.
  - There is no path from data_out_ready[i] to data_out_valid[j], for any i, j.
- Latency: 0 cycles in the best case. If all participating branches are ready, the input is consumed in the same cycle it is presented.
- Once a branch accepts, its valid is low from the next cycle until the token is consumed. A branch never sees the same token twice.
- branch_mask_in changes are ignored while in PARTIAL.
- Reset asserted mid-token clears all progress. After release, the held token is re-offered to all branches in its mask.

## Configuration
- FORK_CTRL_WATCHDOG_EN defined:
  - WD_W-bit counter increments each cycle with data_in_valid & ~data_in_ready, saturating at all-ones.
  - Counter clears on input handshake or when data_in_valid is low.
  - stall_out = (count >= WD_LIMIT), registered, so it asserts one cycle after the count reaches WD_LIMIT.
- Undefined: counter not instantiated, and stall_out is tied to 0.

## Structure
- Package fork_ctrl_pkg:
  - typedef enum logic {FORK_IDLE, FORK_PARTIAL} fork_state_t.
  - Default WD_W and WD_LIMIT localparams.
- Sub-module fork_ctrl_watchdog: the saturating stall counter, instantiated only under FORK_CTRL_WATCHDOG_EN.

## Test plan
- N=4, mask 1111, all ready, one token → data_in_ready=1 in cycle 0, all 4 valids high for exactly one cycle.
- N=4, mask 1111:
  - Cycle 0: ready=0011.
  - Cycle 2: ready=1100.
  - Expected: data_out_valid = 1111 in cycle 0, then 1100; data_in_ready=1 only in cycle 2; pending_out=1100 during cycle 1.
- N=4, mask 0101, all ready → valids 0101 only; token consumed in cycle 0. With mask 0000 → data_in_ready=1, valids 0000.
- In PARTIAL after branch 0 accepts under mask 0011, change branch_mask_in to 1111 → branches 2 and 3 never see valid, and the token completes when branch 1 is ready.
- Assert rst while in PARTIAL (done=0001) → outputs 0 immediately. After release, branch 0 is offered the token again.
- FORK_CTRL_WATCHDOG_EN, WD_LIMIT=8, branch 3 held not-ready → stall_out rises on the cycle after the 8th stalled cycle, and clears the cycle after the handshake.
